// File: rtl/fifo_pkg.sv
// Shared constants, bundled status type and elaboration helpers for the flag-rich sync FIFO.
package fifo_pkg;

  localparam int DEF_SIZE_DATA  = 32'd8;
  localparam int DEF_SIZE_DEPTH = 32'd16;
  localparam int DEF_SIZE_ADDR  = $clog2(DEF_SIZE_DEPTH);
  localparam int STATUS_CNT_W   = DEF_SIZE_ADDR + 32'd1;

  typedef struct packed {
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [STATUS_CNT_W-1:0] count;
  } fifo_status_t;

  function automatic logic is_pow2(input int v);
    return (v >= 32'd2) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Storage array: synchronous write port, asynchronous read port, no reset on contents.
module fifo_ram_dp
  import fifo_pkg::*;
#(
  parameter int SIZE_DATA  = DEF_SIZE_DATA,
  parameter int SIZE_DEPTH = DEF_SIZE_DEPTH,
  parameter int SIZE_ADDR  = $clog2(SIZE_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [SIZE_ADDR-1:0] i_waddr,
  input  logic [SIZE_DATA-1:0] i_wdata,
  input  logic [SIZE_ADDR-1:0] i_raddr,
  output logic [SIZE_DATA-1:0] o_rdata
);

  logic [SIZE_DATA-1:0] mem_q [SIZE_DEPTH];

  // write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with fill count, almost flags, sticky errors, flush and optional FWFT read.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int SIZE_DATA  = DEF_SIZE_DATA,
  parameter int SIZE_DEPTH = DEF_SIZE_DEPTH,
  parameter int SIZE_ADDR  = $clog2(SIZE_DEPTH),
  parameter int AF_THRESH  = SIZE_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_wr_en,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_rd_en,
  input  logic                 i_clr_err,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  if (!is_pow2(SIZE_DEPTH)) begin : g_bad_depth
    $error("fifo_sync_flags: SIZE_DEPTH must be a power of two >= 2");
  end

  localparam logic [SIZE_ADDR:0] AF_C  = (SIZE_ADDR + 1)'(AF_THRESH);
  localparam logic [SIZE_ADDR:0] AE_C  = (SIZE_ADDR + 1)'(AE_THRESH);
  localparam logic [SIZE_ADDR:0] ONE_C = (SIZE_ADDR + 1)'(1);

  logic [SIZE_ADDR:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_s;
  logic                 full_s, empty_s, wr_acc_s, rd_acc_s;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic [SIZE_DATA-1:0] ram_rdata_s;

  // status decode from registered pointers only; the top bit is the wrap bit
  always_comb begin
    count_s = wr_ptr_q - rd_ptr_q;
    full_s  = (wr_ptr_q[SIZE_ADDR-1:0] == rd_ptr_q[SIZE_ADDR-1:0]) &&
              (wr_ptr_q[SIZE_ADDR] != rd_ptr_q[SIZE_ADDR]);
    empty_s = (wr_ptr_q == rd_ptr_q);
  end

  assign o_full         = full_s;
  assign o_empty        = empty_s;
  assign o_count        = count_s;
  assign o_almost_full  = (count_s >= AF_C);
  assign o_almost_empty = (count_s <= AE_C);
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

  // accept/advance decisions; flush overrides both requests
  always_comb begin
    wr_acc_s = i_wr_en & ~full_s & ~i_flush;
    rd_acc_s = i_rd_en & ~empty_s & ~i_flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_acc_s ? (wr_ptr_q + ONE_C) : wr_ptr_q;
      rd_ptr_d = rd_acc_s ? (rd_ptr_q + ONE_C) : rd_ptr_q;
    end
    ovf_d = (i_wr_en & full_s & ~i_flush) | (ovf_q & ~i_clr_err);
    udf_d = (i_rd_en & empty_s & ~i_flush) | (udf_q & ~i_clr_err);
  end

  // pointer and sticky error state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram_dp #(
    .SIZE_DATA (SIZE_DATA),
    .SIZE_DEPTH(SIZE_DEPTH),
    .SIZE_ADDR (SIZE_ADDR)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (wr_acc_s),
    .i_waddr(wr_ptr_q[SIZE_ADDR-1:0]),
    .i_wdata(i_data),
    .i_raddr(rd_ptr_q[SIZE_ADDR-1:0]),
    .o_rdata(ram_rdata_s)
  );

  if (FWFT != 0) begin : g_fwft
    assign o_data  = ram_rdata_s;
    assign o_valid = ~empty_s;
  end else begin : g_std
    logic [SIZE_DATA-1:0] data_q, data_d;
    logic                 valid_q, valid_d;

    // registered read: data updates only on an accepted read, otherwise holds
    always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (rd_acc_s) begin
        data_d  = ram_rdata_s;
        valid_d = 1'b1;
      end else begin
        data_d  = data_q;
        valid_d = 1'b0;
      end
    end

    // read data register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: one standard-mode and one FWFT instance, depth 16.
module tb_fifo_sync_flags;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_flush = 1'b0, s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
  logic [7:0] s_din = 8'h00, s_do;
  logic       s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [4:0] s_cnt;

  logic       f_flush = 1'b0, f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
  logic [7:0] f_din = 8'h00, f_do;
  logic       f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_sync_flags #(.SIZE_DATA(8), .SIZE_DEPTH(16), .FWFT(0)) dut_std (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(s_flush), .i_wr_en(s_wr), .i_data(s_din),
    .i_rd_en(s_rd), .i_clr_err(s_clr), .o_data(s_do), .o_valid(s_vld), .o_full(s_full),
    .o_empty(s_empty), .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_cnt),
    .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  fifo_sync_flags #(.SIZE_DATA(8), .SIZE_DEPTH(16), .FWFT(1)) dut_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(f_flush), .i_wr_en(f_wr), .i_data(f_din),
    .i_rd_en(f_rd), .i_clr_err(f_clr), .o_data(f_do), .o_valid(f_vld), .o_full(f_full),
    .o_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_cnt),
    .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_std_errors();
    s_clr = 1'b1; tick(); s_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got, exp;
    rst_n = 1'b0;
    #12;
    got = {s_do, s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, 1'b0};
    exp = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_std_flags got=%h exp=%h", got, exp); end
    n_checks++;
    if (s_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_std_count got=%0d exp=0", s_cnt); end
    n_checks++;
    if ({f_vld, f_empty, f_cnt} !== {1'b0, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL reset_fwft got vld=%b empty=%b cnt=%0d exp 0/1/0", f_vld, f_empty, f_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      s_wr = 1'b1; s_din = 8'(i);
      tick();
      n_checks++;
      if (s_cnt !== 5'(i + 1) || s_af !== (i + 1 >= 14) || s_full !== (i + 1 == 16) ||
          s_ae !== (i + 1 <= 2) || s_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_flags[%0d] got cnt=%0d af=%b full=%b ae=%b empty=%b exp cnt=%0d af=%b full=%b ae=%b empty=0",
                 i, s_cnt, s_af, s_full, s_ae, s_empty, i + 1, (i + 1 >= 14), (i + 1 == 16), (i + 1 <= 2));
      end
    end
    s_din = 8'hEE;
    tick();
    s_wr = 1'b0;
    n_checks++;
    if (s_ovf !== 1'b1 || s_cnt !== 5'd16 || s_full !== 1'b1) begin
      n_fail++; $display("FAIL overflow got ovf=%b cnt=%0d full=%b exp 1/16/1", s_ovf, s_cnt, s_full);
    end
    for (int i = 0; i < 16; i++) begin
      s_rd = 1'b1;
      tick();
      n_checks++;
      if (s_vld !== 1'b1 || s_do !== 8'(i) || s_cnt !== 5'(15 - i)) begin
        n_fail++;
        $display("FAIL drain[%0d] got vld=%b data=%h cnt=%0d exp 1/%h/%0d", i, s_vld, s_do, s_cnt, 8'(i), 15 - i);
      end
    end
    s_rd = 1'b0;
    tick();
    n_checks++;
    if (s_vld !== 1'b0 || s_empty !== 1'b1 || s_do !== 8'h0F) begin
      n_fail++; $display("FAIL drain_idle got vld=%b empty=%b data=%h exp 0/1/0f", s_vld, s_empty, s_do);
    end
    clear_std_errors();
    n_checks++;
    if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", s_ovf); end
  endtask

  task automatic test_underflow();
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    n_checks++;
    if (s_udf !== 1'b1 || s_vld !== 1'b0 || s_cnt !== 5'd0) begin
      n_fail++; $display("FAIL underflow got udf=%b vld=%b cnt=%0d exp 1/0/0", s_udf, s_vld, s_cnt);
    end
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    n_checks++;
    if (s_udf !== 1'b0) begin n_fail++; $display("FAIL udf_clear got=%b exp=0", s_udf); end
    s_clr = 1'b1; s_rd = 1'b1;
    tick();
    s_clr = 1'b0; s_rd = 1'b0;
    n_checks++;
    if (s_udf !== 1'b1) begin n_fail++; $display("FAIL udf_set_wins got=%b exp=1", s_udf); end
    clear_std_errors();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      s_wr = 1'b1; s_din = 8'(i);
      tick();
    end
    s_rd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      s_din = 8'(8 + k);
      tick();
      n_checks++;
      if (s_cnt !== 5'd8 || s_vld !== 1'b1 || s_do !== 8'(k)) begin
        n_fail++;
        $display("FAIL b2b[%0d] got cnt=%0d vld=%b data=%h exp 8/1/%h", k, s_cnt, s_vld, s_do, 8'(k));
      end
    end
    s_wr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (s_vld !== 1'b1 || s_do !== 8'(40 + k)) begin
        n_fail++; $display("FAIL b2b_tail[%0d] got vld=%b data=%h exp 1/%h", k, s_vld, s_do, 8'(40 + k));
      end
    end
    s_rd = 1'b0;
    tick();
    n_checks++;
    if (s_cnt !== 5'd0 || s_ovf !== 1'b0 || s_udf !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end got cnt=%0d ovf=%b udf=%b exp 0/0/0", s_cnt, s_ovf, s_udf);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      s_wr = 1'b1; s_din = 8'(8'h80 + i);
      tick();
    end
    s_rd = 1'b1; s_din = 8'hCC;
    tick();
    s_wr = 1'b0;
    n_checks++;
    if (s_cnt !== 5'd15 || s_ovf !== 1'b1 || s_vld !== 1'b1 || s_do !== 8'h80) begin
      n_fail++; $display("FAIL full_both got cnt=%0d ovf=%b vld=%b data=%h exp 15/1/1/80", s_cnt, s_ovf, s_vld, s_do);
    end
    for (int i = 0; i < 15; i++) tick();
    s_rd = 1'b0;
    n_checks++;
    if (s_cnt !== 5'd0 || s_do !== 8'h8F) begin
      n_fail++; $display("FAIL full_both_drain got cnt=%0d data=%h exp 0/8f", s_cnt, s_do);
    end
    clear_std_errors();
    s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h5A;
    tick();
    s_wr = 1'b0; s_rd = 1'b0;
    n_checks++;
    if (s_cnt !== 5'd1 || s_udf !== 1'b1 || s_vld !== 1'b0 || s_ovf !== 1'b0) begin
      n_fail++; $display("FAIL empty_both got cnt=%0d udf=%b vld=%b ovf=%b exp 1/1/0/0", s_cnt, s_udf, s_vld, s_ovf);
    end
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    n_checks++;
    if (s_do !== 8'h5A || s_vld !== 1'b1 || s_cnt !== 5'd0) begin
      n_fail++; $display("FAIL empty_both_read got data=%h vld=%b cnt=%0d exp 5a/1/0", s_do, s_vld, s_cnt);
    end
    clear_std_errors();
  endtask

  task automatic test_fwft();
    n_checks++;
    if (f_vld !== 1'b0 || f_empty !== 1'b1) begin
      n_fail++; $display("FAIL fwft_idle got vld=%b empty=%b exp 0/1", f_vld, f_empty);
    end
    f_wr = 1'b1; f_din = 8'hA5;
    tick();
    f_wr = 1'b0;
    n_checks++;
    if (f_vld !== 1'b1 || f_do !== 8'hA5 || f_cnt !== 5'd1) begin
      n_fail++; $display("FAIL fwft_fall got vld=%b data=%h cnt=%0d exp 1/a5/1", f_vld, f_do, f_cnt);
    end
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    n_checks++;
    if (f_empty !== 1'b1 || f_vld !== 1'b0 || f_udf !== 1'b0) begin
      n_fail++; $display("FAIL fwft_pop got empty=%b vld=%b udf=%b exp 1/0/0", f_empty, f_vld, f_udf);
    end
  endtask

  task automatic test_flush();
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_wr = 1'b1; s_din = 8'(8'h30 + i);
      tick();
    end
    s_wr = 1'b0; s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    n_checks++;
    if (s_cnt !== 5'd9 || s_do !== 8'h30 || s_vld !== 1'b1) begin
      n_fail++; $display("FAIL pre_flush got cnt=%0d data=%h vld=%b exp 9/30/1", s_cnt, s_do, s_vld);
    end
    s_flush = 1'b1; s_wr = 1'b1; s_din = 8'hFF;
    tick();
    s_flush = 1'b0; s_wr = 1'b0;
    n_checks++;
    if (s_cnt !== 5'd0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_af !== 1'b0 || s_vld !== 1'b0) begin
      n_fail++; $display("FAIL flush_state got cnt=%0d empty=%b ae=%b af=%b vld=%b exp 0/1/1/0/0",
                         s_cnt, s_empty, s_ae, s_af, s_vld);
    end
    n_checks++;
    if (s_udf !== 1'b1 || s_ovf !== 1'b0 || s_do !== 8'h30) begin
      n_fail++; $display("FAIL flush_keep got udf=%b ovf=%b data=%h exp 1/0/30", s_udf, s_ovf, s_do);
    end
    tick();
    n_checks++;
    if (s_cnt !== 5'd0) begin n_fail++; $display("FAIL flush_no_write got cnt=%0d exp 0", s_cnt); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      s_wr = 1'b1; s_din = 8'(8'h11 * (i + 1));
      f_wr = 1'b1; f_din = 8'(8'h11 * (i + 1));
      tick();
    end
    s_wr = 1'b0; f_wr = 1'b0; s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    n_checks++;
    if (s_vld !== 1'b1 || s_do !== 8'h11 || s_cnt !== 5'd2 || f_cnt !== 5'd3) begin
      n_fail++; $display("FAIL pre_reset got vld=%b data=%h cnt=%0d fcnt=%0d exp 1/11/2/3", s_vld, s_do, s_cnt, f_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_do, s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_cnt} !==
        {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL async_reset_std got data=%h vld=%b empty=%b ae=%b udf=%b cnt=%0d exp 00/0/1/1/0/0",
                         s_do, s_vld, s_empty, s_ae, s_udf, s_cnt);
    end
    n_checks++;
    if (f_vld !== 1'b0 || f_empty !== 1'b1 || f_cnt !== 5'd0) begin
      n_fail++; $display("FAIL async_reset_fwft got vld=%b empty=%b cnt=%0d exp 0/1/0", f_vld, f_empty, f_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_simultaneous();
    test_fwft();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO and the next generation of the team's basic pointer-based FIFO. It adds:
- fill count
- programmable almost-full and almost-empty flags
- selectable standard or first-word-fall-through (FWFT) read mode
- synchronous flush
- sticky overflow and underflow error flags

It sits between producer and consumer blocks in the same clock domain, as a drop-in buffer with richer status.

Parameters:
SIZE_DATA, 8, data word width in bits (≥1)
SIZE_DEPTH, 16, number of entries; power of two ≥2, otherwise an elaboration error
SIZE_ADDR, $clog2(SIZE_DEPTH), address width (derived, not overridden)
AF_THRESH, SIZE_DEPTH-2, o_almost_full asserts when count ≥ AF_THRESH (1..SIZE_DEPTH)
AE_THRESH, 2, o_almost_empty asserts when count ≤ AE_THRESH (0..SIZE_DEPTH-1)
FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  synchronous flush; empties the FIFO
i_wr_en  in  1  write request
i_data  in  SIZE_DATA  write data
i_rd_en  in  1  read request (in FWFT mode: pop the head word)
i_clr_err  in  1  clears the sticky error flags
o_data  out  SIZE_DATA  read data
o_valid  out  1  o_data holds valid read data
o_full  out  1  count == SIZE_DEPTH
o_empty  out  1  count == 0
o_almost_full  out  1  count ≥ AF_THRESH
o_almost_empty  out  1  count ≤ AE_THRESH
o_count  out  SIZE_ADDR+1  current occupancy, 0..SIZE_DEPTH
o_overflow  out  1  sticky: a write was attempted while full
o_underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Clock and reset (already decided): one clock, i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values:
  - pointers, o_count, o_data, o_valid, o_full, o_overflow, o_underflow = 0
  - o_empty = 1, o_almost_empty = 1, o_almost_full = 0
- Pointers: wr_ptr and rd_ptr are SIZE_ADDR+1 bits, with the extra bit used as the wrap bit.
  - Address bits wrap naturally from SIZE_DEPTH-1 to 0.
  - o_full: address bits equal and wrap bits differ.
  - o_empty: pointers fully equal.
- o_count = wr_ptr - rd_ptr, modulo 2^(SIZE_ADDR+1).
- All flags are combinational decodes of the registered pointers; no flag depends on same-cycle inputs.
- Accepted operations:
  - wr_acc = i_wr_en & ~o_full & ~i_flush
  - rd_acc = i_rd_en & ~o_empty & ~i_flush
- Simultaneous operations:
  - Write while full is rejected even if a read is accepted in the same cycle.
  - Read while empty is rejected even if a write is accepted in the same cycle.
  - wr_acc & rd_acc together: both pointers advance and the count is unchanged.
- Write: on wr_acc, mem[wr_ptr addr] ← i_data at the clock edge and wr_ptr increments.
- Standard mode (FWFT=0):
  - On rd_acc, o_data ← mem[rd_ptr addr] at the edge and rd_ptr increments.
  - o_valid = 1 for exactly the cycle after each rd_acc, else 0.
  - o_data holds its last value when there is no rd_acc.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - o_data = mem[rd_ptr addr] combinationally; o_valid = ~o_empty.
  - rd_acc pops the head word.
  - A word written at edge N is visible on o_data after edge N (the write-to-o_valid latency is 1 cycle).
- Errors:
  - o_overflow set on i_wr_en & o_full & ~i_flush.
  - o_underflow set on i_rd_en & o_empty & ~i_flush.
  - Both flags are cleared by i_clr_err; set wins over clear in the same cycle.
  - Flush does not clear them.
- Flush:
  - At the edge, both pointers go to 0 and o_valid goes to 0.
  - Memory contents are not cleared.
  - In standard mode o_data holds its value.
  - Flush takes priority over any write or read in the same cycle.
- Reset during operation: asynchronous, returns all state to the reset values immediately; in-flight data is lost.

Decomposition:
- Package fifo_pkg: clog2-derived constants, and a status struct type bundling {full, empty, almost_full, almost_empty, count} for consumers that prefer a bundled view.
- Sub-module fifo_ram_dp:
  - parameters SIZE_DATA, SIZE_DEPTH, SIZE_ADDR
  - synchronous write, asynchronous read, no reset on the storage array
  - the top level owns the o_data register in standard mode

Test Plan:
- DEPTH=16, FWFT=0: write 0x00..0x0F, with i_wr_en held on a 17th cycle -> o_full=1 after 16th write, o_count=16, o_almost_full from count 14, o_overflow=1, then 16 reads return 0x00..0x0F, each with o_valid 1 cycle after i_rd_en.
- Read from empty after reset -> o_underflow=1, o_valid stays 0, o_count stays 0; pulse i_clr_err -> o_underflow=0; i_clr_err in the same cycle as a new underflow read -> o_underflow stays 1.
- Fill to 8, then 40 cycles of simultaneous write/read with an incrementing pattern -> o_count constant at 8, pointers wrap past 15, read data is in order with no gaps.
- Full with i_wr_en=i_rd_en=1 -> read accepted, write rejected, o_overflow=1, o_count=15; empty with both requests -> write accepted, read rejected, o_underflow=1, o_count=1.
- FWFT=1: write 0xA5 at edge N -> o_valid=1 and o_data=0xA5 in cycle N+1 with no read; pop -> o_empty=1, o_valid=0.
- Fill to 10, assert i_flush together with i_wr_en -> next cycle o_count=0, o_empty=1, o_almost_empty=1, sticky flags unchanged; assert i_rst_n low mid-stream -> all outputs go to reset values without waiting for a clock edge.
